// File: rtl/imm_ext_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe_if
// Bundle of the immediate-extension pipeline's handshake and data signals.
//
// Handshake: a beat moves across a boundary on a rising clock edge exactly
// when valid and ready are both high in the cycle before that edge. A producer
// holding valid must keep its data stable until the beat is taken. ready may
// depend combinationally on the consumer's own downstream ready, but never on
// valid of the same boundary.
//
// Signals:
//   in_valid  - upstream beat present
//   in_ready  - unit accepts the beat this cycle
//   imm       - raw immediate field (IN_W bits)
//   mode      - 00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset
//   flush     - synchronous pipeline kill
//   out_valid - result valid
//   out_ready - downstream accepts result
//   y         - extended result (OUT_W bits)
//
// Modports:
//   master - the side that drives the beats and consumes results (decode/EX)
//   slave  - the extension unit itself
// -----------------------------------------------------------------------------
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  imm;
    logic [1:0]       mode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y;

    modport master (
        output in_valid,
        output imm,
        output mode,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y
    );

    modport slave (
        input  in_valid,
        input  imm,
        input  mode,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
// Pipelined immediate-extension unit sitting on the decode/execute boundary.
// The raw immediate is extended combinationally according to mode and then
// carried through STAGES elastic register stages; latency equals STAGES.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears every stage (valid and data)
//   bus   - imm_ext_pipe_if.slave: in_valid/in_ready/imm/mode/flush on the
//           input side, out_valid/out_ready/y on the output side
//
// Parameters:
//   IN_W   - immediate width, 2 <= IN_W <= OUT_W
//   OUT_W  - result width
//   STAGES - register stages, 1..4
// -----------------------------------------------------------------------------
module imm_ext_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_ext_pipe_if.slave  bus
);

    // Reject unsupported configurations at elaboration time.
    generate
        if (STAGES < 1 || STAGES > 4 || IN_W < 2 || IN_W > OUT_W) begin : g_bad_params
            $error("imm_ext_pipe: illegal parameters IN_W=%0d OUT_W=%0d STAGES=%0d",
                   IN_W, OUT_W, STAGES);
        end
    endgenerate

    localparam int UPPER_SHIFT = OUT_W - IN_W;

    // ---------------------------------------------------------------------
    // Extension (combinational, input side)
    // ---------------------------------------------------------------------
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_val;

    // The size cast keeps the operand's signedness, so the signed form
    // replicates imm's MSB and the unsigned form pads with zeros. Both work
    // unchanged when OUT_W == IN_W (no padding at all).
    assign zext = OUT_W'(bus.imm);
    assign sext = OUT_W'($signed(bus.imm));

    always_comb begin
        ext_val = zext;
        case (bus.mode)
            2'b00: ext_val = zext;
            2'b01: ext_val = sext;
            2'b10: ext_val = zext << UPPER_SHIFT;
            2'b11: ext_val = sext << 2;  // word offset; top two bits fall off
            default: ext_val = zext;
        endcase
    end

    // ---------------------------------------------------------------------
    // Elastic pipeline state
    // ---------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [OUT_W-1:0]  data_q [STAGES];
    logic [OUT_W-1:0]  data_d [STAGES];
    logic [STAGES:0]   ready;

    // ready[k] = ~valid[k] | ready[k+1], unrolled with a running OR so the
    // chain has no self-referencing vector: a stage can take a beat when it
    // or any stage after it has a hole, or when the output is being drained.
    always_comb begin : ready_chain
        logic acc;
        ready         = '0;
        acc           = bus.out_ready;
        ready[STAGES] = acc;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc      = acc | ~valid_q[k];
            ready[k] = acc;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;

        // Stage 0 loads from the input side.
        if (ready[0]) begin
            valid_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                data_d[0] = ext_val;
            end
        end

        // Stage k+1 takes stage k's beat, or goes empty when stage k is empty
        // and stage k+1 is free to move on.
        for (int k = 0; k < STAGES - 1; k++) begin
            if (ready[k+1]) begin
                valid_d[k+1] = valid_q[k];
                if (valid_q[k]) begin
                    data_d[k+1] = data_q[k];
                end
            end
        end

        // Flush wins over every transfer. Data may go stale; with all valid
        // bits low it cannot be observed.
        if (bus.flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.in_ready  = ready[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.y         = data_q[STAGES-1];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_pipe
// Bench for imm_ext_pipe (IN_W=16, OUT_W=32, STAGES=3). The reference keeps
// every accepted beat in a queue together with the edge that captured it; a
// beat is visible at the output once it is the oldest and STAGES-1 further
// edges have passed. Occupancy equals the queue length, so the unit must be
// ready whenever fewer than STAGES beats are in flight or the output drains.
// -----------------------------------------------------------------------------
module tb_imm_ext_pipe;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 32;
    localparam int STAGES = 3;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    imm_ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    imm_ext_pipe #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .STAGES (STAGES)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------
    int               n_checks = 0;
    int               n_fail   = 0;
    int               edge_cnt = 0;
    logic [OUT_W-1:0] exp_q[$];
    int               stamp_q[$];

    task automatic check(input string tag, input logic [OUT_W-1:0] got,
                         input logic [OUT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference extension from plain integer arithmetic.
    function automatic logic [OUT_W-1:0] ext_ref(input logic [IN_W-1:0] v,
                                                  input logic [1:0] m);
        longint uv;
        longint sv;
        uv = longint'(v);
        sv = v[IN_W-1] ? (uv - (longint'(1) << IN_W)) : uv;
        case (m)
            2'd0:    return OUT_W'(uv);
            2'd1:    return OUT_W'(sv);
            2'd2:    return OUT_W'(uv * (longint'(1) << (OUT_W - IN_W)));
            default: return OUT_W'(sv * 4);
        endcase
    endfunction

    function automatic bit head_visible();
        if (exp_q.size() == 0) return 1'b0;
        return (edge_cnt - stamp_q[0]) >= (STAGES - 1);
    endfunction

    // ---------------------------------------------------------------------
    // Driver: one cycle. Called just after a falling edge; returns at the
    // next falling edge.
    // ---------------------------------------------------------------------
    task automatic step(input logic v, input logic [IN_W-1:0] d,
                        input logic [1:0] m, input logic f, input logic ordy);
        bit exp_vld;
        bit exp_rdy;
        bit fire_out;
        bit acc;
        bus.in_valid  = v;
        bus.imm       = d;
        bus.mode      = m;
        bus.flush     = f;
        bus.out_ready = ordy;
        #1;
        exp_vld = head_visible();
        exp_rdy = (exp_q.size() < STAGES) || ordy;
        check("in_ready", OUT_W'(bus.in_ready), OUT_W'(exp_rdy));
        check("out_valid", OUT_W'(bus.out_valid), OUT_W'(exp_vld));
        if (exp_vld) check("y", bus.y, exp_q[0]);
        fire_out = exp_vld && ordy;
        acc      = v && exp_rdy;
        @(posedge clk);
        edge_cnt++;
        if (fire_out) begin
            void'(exp_q.pop_front());
            void'(stamp_q.pop_front());
        end
        if (f) begin
            exp_q.delete();
            stamp_q.delete();
        end else if (acc) begin
            exp_q.push_back(ext_ref(d, m));
            stamp_q.push_back(edge_cnt);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 2'd0, 1'b0, ordy);
    endtask

    // Single beat with a hand-computed expected result.
    task automatic send_one(input logic [IN_W-1:0] d, input logic [1:0] m,
                            input logic [OUT_W-1:0] expv);
        step(1'b1, d, m, 1'b0, 1'b1);
        idle(STAGES - 1, 1'b1);
        check("dir_valid", OUT_W'(bus.out_valid), OUT_W'(1'b1));
        check("dir_y", bus.y, expv);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.imm       = '0;
        bus.mode      = 2'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", OUT_W'(bus.out_valid), '0);
        check("rst_y", bus.y, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", OUT_W'(bus.in_ready), OUT_W'(1'b1));
        @(negedge clk);

        // Extension modes
        send_one(16'h8001, 2'd1, 32'hFFFF_8001);
        send_one(16'h8001, 2'd0, 32'h0000_8001);
        send_one(16'h1234, 2'd2, 32'h1234_0000);
        send_one(16'hFFFF, 2'd3, 32'hFFFF_FFFC);
        send_one(16'h0004, 2'd3, 32'h0000_0010);
        send_one(16'h7FFF, 2'd1, 32'h0000_7FFF);
        idle(STAGES + 1, 1'b1);

        // Back-to-back stream, full throughput
        for (int i = 1; i <= 8; i++) step(1'b1, IN_W'(i), 2'd0, 1'b0, 1'b1);
        idle(STAGES + 1, 1'b1);

        // Stall: output blocked, pipeline fills, then drains in order
        for (int i = 0; i < 5; i++) step(1'b1, IN_W'(16'hA0 + i), 2'd1, 1'b0, 1'b0);
        check("stall_in_ready_low", OUT_W'(bus.in_ready), '0);
        check("stall_y_hold", bus.y, 32'h0000_00A0);
        idle(STAGES + 2, 1'b1);

        // Flush with a beat offered in the same cycle
        step(1'b1, 16'h0011, 2'd0, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 2'd0, 1'b0, 1'b0);
        step(1'b1, 16'h7FFF, 2'd0, 1'b1, 1'b0);
        idle(STAGES + 1, 1'b1);
        step(1'b1, 16'h0033, 2'd0, 1'b0, 1'b1);
        idle(STAGES + 1, 1'b1);

        // Flush together with an output handshake
        for (int i = 0; i < STAGES + 1; i++) step(1'b1, IN_W'(16'h50 + i), 2'd0, 1'b0, 1'b1);
        step(1'b0, '0, 2'd0, 1'b1, 1'b1);
        idle(STAGES + 1, 1'b1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < STAGES + 1; i++) step(1'b1, IN_W'(16'hC0 + i), 2'd2, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", OUT_W'(bus.out_valid), '0);
        check("arst_y", bus.y, '0);
        exp_q.delete();
        stamp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h8421, 2'd3, 1'b0, 1'b1);
        idle(STAGES + 1, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0),
                 IN_W'($urandom),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        idle(STAGES + 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
